dma_priority_arbiter: RTL

Channel arbitration and bus-hold sequencer for the 8237A-style DMA controller. It samples the NUM_CH DREQ lines plus the software request bits and applies the mask register. It resolves one winner under fixed or rotating priority and runs the HRQ/HLDA handshake with the CPU. It then drives DACK and the one-hot VALID_DREQ grant consumed by DmaTimingControl, and releases the bus when the timing FSM signals end of transfer.

---
 rtl/dma_priority_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dma_priority_arbiter.sv
// ---------------------------------------------------------------------------
// dma_priority_arbiter
//
// Channel arbitration and bus-hold sequencer for an 8237A-style DMA
// controller. Hardware DREQ lines are synchronised, polarity-corrected and
// masked, then merged with the software request bits. One winner is picked
// by a circular search starting at the highest-priority pointer. The block
// then runs the HRQ/HLDA handshake with the CPU, presents the grant for a
// single transfer, and releases the bus when the timing FSM reports the end
// of the transfer.
//
// Ports
//   i_clk            system clock, all state changes on the rising edge
//   i_reset          synchronous active-high reset
//   i_dreq           raw asynchronous channel requests
//   i_hlda           hold acknowledge from the CPU
//   i_cmd_disable    1 blocks new arbitration (an open grant is not aborted)
//   i_cmd_rotate     1 rotating priority, 0 fixed priority (ch0 highest)
//   i_cmd_dreq_low   1 means DREQ lines are active low
//   i_cmd_dack_high  1 means DACK lines are active high
//   i_mask           1 blocks the matching hardware DREQ
//   i_sw_req         software request bits, not affected by the mask
//   i_cycle_done     end-of-transfer pulse from the timing FSM
//   i_eop            terminal count / external EOP, coincident with done
//   o_hrq            hold request to the CPU
//   o_dack           channel acknowledge at the programmed polarity
//   o_valid_dreq     one-hot granted channel, zero when no grant is active
//   o_grant_ch       encoded index of the latched winner
//   o_sw_req_clr     one-cycle pulse clearing the serviced software request
//   o_busy           high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module dma_priority_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NUM_CH-1:0] i_dreq,
  input  logic              i_hlda,
  input  logic              i_cmd_disable,
  input  logic              i_cmd_rotate,
  input  logic              i_cmd_dreq_low,
  input  logic              i_cmd_dack_high,
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [NUM_CH-1:0] i_sw_req,
  input  logic              i_cycle_done,
  input  logic              i_eop,
  output logic              o_hrq,
  output logic [NUM_CH-1:0] o_dack,
  output logic [NUM_CH-1:0] o_valid_dreq,
  output logic [CW-1:0]     o_grant_ch,
  output logic [NUM_CH-1:0] o_sw_req_clr,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_REQ,
    ACTIVE,
    RELEASE
  } state_t;

  state_t            r_state;
  logic [NUM_CH-1:0] r_dreqMeta;
  logic [NUM_CH-1:0] r_dreqSync;
  logic [CW-1:0]     r_prioHi;
  logic [CW-1:0]     r_grant;
  logic              r_hrq;
  logic [NUM_CH-1:0] r_valid;
  logic [NUM_CH-1:0] r_swClr;

  logic [NUM_CH-1:0] w_dreqLevel;
  logic [NUM_CH-1:0] w_eff;
  logic [CW-1:0]     w_prioSearch;
  logic [CW-1:0]     w_winner;
  logic              w_found;
  logic [CW:0]       w_sum;
  logic [CW-1:0]     w_nextPrio;
  logic [NUM_CH-1:0] w_grantOneHot;

  // Polarity correction happens after the synchroniser, so a polarity
  // change only affects already-synchronised levels.
  assign w_dreqLevel = r_dreqSync ^ {NUM_CH{i_cmd_dreq_low}};
  assign w_eff       = (w_dreqLevel & ~i_mask) | i_sw_req;

  // In fixed mode the search always starts at channel 0.
  assign w_prioSearch = i_cmd_rotate ? r_prioHi : '0;

  // Circular first-set search starting at w_prioSearch. The index is kept
  // one bit wider than the channel index so the wrap can be done with a
  // single subtraction for any channel count, not just powers of two.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum = {1'b0, w_prioSearch} + (CW+1)'(i);
      if (w_sum >= (CW+1)'(NUM_CH)) begin
        w_sum = w_sum - (CW+1)'(NUM_CH);
      end
      if (!w_found && w_eff[w_sum[CW-1:0]]) begin
        w_winner = w_sum[CW-1:0];
        w_found  = 1'b1;
      end
    end
  end

  assign w_nextPrio    = (r_grant == CW'(NUM_CH - 1)) ? '0 : r_grant + CW'(1);
  assign w_grantOneHot = NUM_CH'(1) << r_grant;

  // Single sequencer: synchroniser, arbitration decision, handshake and
  // registered grant outputs all advance together. The winner is latched on
  // leaving IDLE and is never re-evaluated until the sequencer returns there.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_dreqMeta <= '0;
      r_dreqSync <= '0;
      r_prioHi   <= '0;
      r_grant    <= '0;
      r_hrq      <= 1'b0;
      r_valid    <= '0;
      r_swClr    <= '0;
    end else begin
      r_dreqMeta <= i_dreq;
      r_dreqSync <= r_dreqMeta;
      r_swClr    <= '0;
      case (r_state)
        IDLE: begin
          if ((|w_eff) && !i_cmd_disable && !i_hlda) begin
            r_grant <= w_winner;
            r_hrq   <= 1'b1;
            r_state <= HOLD_REQ;
          end
        end
        HOLD_REQ: begin
          if (i_hlda) begin
            r_valid <= w_grantOneHot;
            r_state <= ACTIVE;
          end
        end
        ACTIVE: begin
          // End of transfer wins over a simultaneous HLDA drop.
          if (i_cycle_done) begin
            r_hrq    <= 1'b0;
            r_valid  <= '0;
            r_prioHi <= i_cmd_rotate ? w_nextPrio : '0;
            if (i_eop) begin
              r_swClr <= w_grantOneHot;
            end
            r_state  <= RELEASE;
          end else if (!i_hlda) begin
            // CPU took the bus back: abandon the grant without rotating.
            r_hrq   <= 1'b0;
            r_valid <= '0;
            r_state <= IDLE;
          end
        end
        RELEASE: begin
          if (!i_hlda) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_hrq        = r_hrq;
  assign o_valid_dreq = r_valid;
  assign o_grant_ch   = r_grant;
  assign o_sw_req_clr = r_swClr;
  assign o_busy       = (r_state != IDLE);

  // DACK follows the programmed polarity combinationally, so a polarity
  // change is visible without waiting for a clock edge.
  assign o_dack = ~(r_valid ^ {NUM_CH{i_cmd_dack_high}});

endmodule
